// File: rtl/ascon_xor_begin_if.sv
// ascon_xor_begin_if
// Bundles the enables and data paths around the ASCON input-side XOR stage.
// State words are packed as [4:0][63:0]; element [i] is ASCON word x<i>.
//   en_xor_data_i : XOR data_i into word 0
//   en_xor_key_i  : XOR key_i into words 1 and 2
//   state_i       : incoming permutation state (320 bits)
//   data_i        : padded 64-bit AD/plaintext block
//   key_i         : 128-bit key, [127:64] is the high half
//   state_o       : registered XORed state
// Modports: master drives the inputs and observes state_o; slave is the stage.
interface ascon_xor_begin_if;
  logic                  en_xor_data_i;
  logic                  en_xor_key_i;
  logic [4:0][63:0]      state_i;
  logic [63:0]           data_i;
  logic [127:0]          key_i;
  logic [4:0][63:0]      state_o;

  modport master (
    output en_xor_data_i, en_xor_key_i, state_i, data_i, key_i,
    input  state_o
  );

  modport slave (
    input  en_xor_data_i, en_xor_key_i, state_i, data_i, key_i,
    output state_o
  );
endinterface

// File: rtl/ascon_xor_begin.sv
// ascon_xor_begin
// Input-side XOR stage of the ASCON-128 permutation datapath. Optionally XORs
// the data block into x0 and the key into x1/x2, then registers the result so
// the round logic sees the updated state on the next clock. No FSM here; the
// ASCON controller drives the enables.
// Ports:
//   clock_i : rising-edge clock
//   reset_i : synchronous, active-high; clears all five state words
//   bus     : ascon_xor_begin_if.slave (enables, state_i, data_i, key_i, state_o)
// Build option:
//   XOR_BEGIN_BOTH_EN defined   -> both enables high applies data and key XORs
//   XOR_BEGIN_BOTH_EN undefined -> key XOR wins, data XOR suppressed
module ascon_xor_begin (
  input  logic               clock_i,
  input  logic               reset_i,
  ascon_xor_begin_if.slave   bus
);

  logic             data_en_eff;
  logic [4:0][63:0] state_next;

`ifdef XOR_BEGIN_BOTH_EN
  assign data_en_eff = bus.en_xor_data_i;
`else
  // Key has priority when the controller raises both enables together.
  assign data_en_eff = bus.en_xor_data_i & ~bus.en_xor_key_i;
`endif

  always_comb begin
    state_next    = bus.state_i;
    state_next[0] = bus.state_i[0] ^ (data_en_eff ? bus.data_i : 64'h0);
    state_next[1] = bus.state_i[1] ^ (bus.en_xor_key_i ? bus.key_i[127:64] : 64'h0);
    state_next[2] = bus.state_i[2] ^ (bus.en_xor_key_i ? bus.key_i[63:0] : 64'h0);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      bus.state_o <= '0;
    end else begin
      bus.state_o <= state_next;
    end
  end

endmodule

// File: tb/tb_ascon_xor_begin.sv
// tb_ascon_xor_begin
// Drives ascon_xor_begin with the reference test vectors, then randomized
// inputs with occasional resets, comparing state_o against a word-level model.
module tb_ascon_xor_begin;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ascon_xor_begin_if bus ();

  ascon_xor_begin dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: rules for the registered next state, written per word.
  function automatic logic [319:0] model(input logic [4:0][63:0] st, input logic [63:0] d,
                                         input logic [127:0] k, input logic ed, input logic ek,
                                         input logic r);
    logic [63:0] w [5];
    logic        use_data;
    if (r) return '0;
`ifdef XOR_BEGIN_BOTH_EN
    use_data = ed;
`else
    use_data = ed && !ek;
`endif
    for (int i = 0; i < 5; i++) w[i] = st[i];
    if (use_data) w[0] = w[0] ^ d;
    if (ek) begin
      w[1] = w[1] ^ k[127:64];
      w[2] = w[2] ^ k[63:0];
    end
    return {w[4], w[3], w[2], w[1], w[0]};
  endfunction

  task automatic step(input string tag, input logic [4:0][63:0] st, input logic [63:0] d,
                      input logic [127:0] k, input logic ed, input logic ek, input logic r,
                      input logic [319:0] exp);
    @(negedge clk);
    bus.state_i       = st;
    bus.data_i        = d;
    bus.key_i         = k;
    bus.en_xor_data_i = ed;
    bus.en_xor_key_i  = ek;
    rst               = r;
    @(posedge clk);
    #1;
    check(tag, bus.state_o, exp);
  endtask

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  logic [4:0][63:0] st_ref;
  logic [4:0][63:0] st_rnd;
  logic [63:0]      d_ref;
  logic [127:0]     k_ref;
  logic [319:0]     exp_v;
  logic [4:0][63:0] exp_w;

  initial begin
    st_ref[0] = 64'h1b1354db77e0dbb4;
    st_ref[1] = 64'h6f140401cfa0873c;
    st_ref[2] = 64'hd7e8abaf45f2885a;
    st_ref[3] = 64'hc0c5777fa661625e;
    st_ref[4] = 64'hfc4374d28210928c;
    d_ref     = 64'h3230323380000000;
    k_ref     = 128'h000102030405060708090A0B0C0D0E0F;

    // Reset with active enables: output must clear regardless.
    step("reset", st_ref, d_ref, k_ref, 1'b1, 1'b1, 1'b1, '0);
    step("reset_hold", st_ref, d_ref, k_ref, 1'b0, 1'b1, 1'b1, '0);

    // Data XOR (first edge after reset release).
    exp_w = st_ref;
    exp_w[0] = 64'h292366e8f7e0dbb4;
    step("data_xor", st_ref, d_ref, k_ref, 1'b1, 1'b0, 1'b0, exp_w);

    // Key XOR.
    exp_w = st_ref;
    exp_w[1] = 64'h6f150602cba5813b;
    exp_w[2] = 64'hdfe1a1a449ff8655;
    step("key_xor", st_ref, d_ref, k_ref, 1'b0, 1'b1, 1'b0, exp_w);

    // Pass-through.
    step("pass", st_ref, d_ref, k_ref, 1'b0, 1'b0, 1'b0, st_ref);

    // Both enables.
    exp_w = st_ref;
    exp_w[1] = 64'h6f150602cba5813b;
    exp_w[2] = 64'hdfe1a1a449ff8655;
`ifdef XOR_BEGIN_BOTH_EN
    exp_w[0] = 64'h292366e8f7e0dbb4;
`else
    exp_w[0] = 64'h1b1354db77e0dbb4;
`endif
    step("both_en", st_ref, d_ref, k_ref, 1'b1, 1'b1, 1'b0, exp_w);

    // Mid-stream reset while toggling enables every cycle.
    for (int i = 0; i < 8; i++) begin
      logic ed, ek, r;
      ed = i[0];
      ek = ~i[0];
      r  = (i == 4);
      exp_v = model(st_ref, d_ref, k_ref, ed, ek, r);
      step(r ? "mid_reset" : "toggle", st_ref, d_ref, k_ref, ed, ek, r, exp_v);
    end

    // Randomized stimulus, occasional reset.
    for (int i = 0; i < 300; i++) begin
      logic [63:0]  d;
      logic [127:0] k;
      logic         ed, ek, r;
      for (int w = 0; w < 5; w++) st_rnd[w] = r64();
      d  = r64();
      k  = {r64(), r64()};
      ed = 1'($urandom_range(0, 1));
      ek = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 19) == 0);
      exp_v = model(st_rnd, d, k, ed, ek, r);
      step("random", st_rnd, d, k, ed, ek, r, exp_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
